// File: rtl/float_normalizer.sv
// float_normalizer
//   Two-stage post-add normalizer for IEEE-754 single precision.
//   S1 normalizes the raw magnitude sum using the supplied leading-one
//   position; S2 rounds to nearest even and packs the result word.
//   Ready/valid on both sides; a stalled output holds all fields stable.
//
// Ports
//   clk, rst_n                : clock, async active-low reset
//   in_valid / in_ready       : upstream handshake
//   in_sign, in_exp, in_mant  : sign, biased exponent, 25-bit sum (bit 24 carry)
//   in_lead                   : MSB-one position of in_mant (23 when zero)
//   in_guard, in_sticky       : alignment guard / sticky bits
//   out_valid / out_ready     : downstream handshake
//   out_result                : {sign, exp[7:0], frac[22:0]}
//   out_overflow/underflow/zero : saturate-to-inf, flush-to-zero, exact zero
module float_normalizer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_mant,
  input  logic [4:0]  in_lead,
  input  logic        in_guard,
  input  logic        in_sticky,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        out_zero
);

  localparam int STAGES = 2;

  // vld_pipe_q[1] = S1 occupied, vld_pipe_q[2] = S2 occupied (= out_valid)
  logic [STAGES:1] vld_pipe_q;
  logic            s1_adv, s2_adv;

  assign s2_adv   = !vld_pipe_q[2] | out_ready;
  assign s1_adv   = !vld_pipe_q[1] | s2_adv;
  assign in_ready = s1_adv;

  // ---------------- S1: normalize ----------------
  logic               s1_sign_d,   s1_sign_q;
  logic signed [9:0]  s1_exp_d,    s1_exp_q;
  logic [23:0]        s1_mant_d,   s1_mant_q;
  logic               s1_guard_d,  s1_guard_q;
  logic               s1_sticky_d, s1_sticky_q;
  logic               s1_zero_d,   s1_zero_q;
  logic [4:0]         lshift;

  always_comb begin
    s1_sign_d   = in_sign;
    s1_zero_d   = (in_mant == 25'd0);
    s1_exp_d    = $signed({2'b00, in_exp});
    s1_mant_d   = in_mant[23:0];
    s1_guard_d  = in_guard;
    s1_sticky_d = in_sticky;
    lshift      = 5'd23 - in_lead;
    if (in_lead >= 5'd24) begin
      // carry out of the add: one right shift, guard drops into sticky
      s1_mant_d   = in_mant[24:1];
      s1_exp_d    = $signed({2'b00, in_exp}) + 10'sd1;
      s1_guard_d  = in_mant[0];
      s1_sticky_d = in_guard | in_sticky;
    end else if (in_lead < 5'd23) begin
      // cancellation: guard refills the first vacated LSB, zeros after it.
      // Pre-placing guard one position up lets a shift of (k-1) do the job.
      s1_mant_d   = {in_mant[22:0], in_guard} << (lshift - 5'd1);
      s1_exp_d    = $signed({2'b00, in_exp}) - $signed({5'b00000, lshift});
      s1_guard_d  = 1'b0;
      s1_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q[1] <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_exp_q      <= '0;
      s1_mant_q     <= '0;
      s1_guard_q    <= 1'b0;
      s1_sticky_q   <= 1'b0;
      s1_zero_q     <= 1'b0;
    end else if (s1_adv) begin
      vld_pipe_q[1] <= in_valid;
      if (in_valid) begin
        s1_sign_q   <= s1_sign_d;
        s1_exp_q    <= s1_exp_d;
        s1_mant_q   <= s1_mant_d;
        s1_guard_q  <= s1_guard_d;
        s1_sticky_q <= s1_sticky_d;
        s1_zero_q   <= s1_zero_d;
      end
    end
  end

  // ---------------- S2: round + pack ----------------
  logic               rnd_up;
  logic [24:0]        mant_sum;
  logic [23:0]        mant_r;
  logic signed [9:0]  exp_r;
  logic [31:0]        result_d, result_q;
  logic               ovf_d, ovf_q, unf_d, unf_q, zero_d, zero_q;

  always_comb begin
    rnd_up   = s1_guard_q & (s1_sticky_q | s1_mant_q[0]);
    mant_sum = {1'b0, s1_mant_q} + {24'd0, rnd_up};
    mant_r   = mant_sum[23:0];
    exp_r    = s1_exp_q;
    if (mant_sum[24]) begin
      mant_r = 24'h800000;
      exp_r  = s1_exp_q + 10'sd1;
    end
    result_d = {s1_sign_q, exp_r[7:0], mant_r[22:0]};
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    zero_d   = 1'b0;
    if (s1_zero_q) begin
      result_d = 32'h0000_0000;   // always +0
      zero_d   = 1'b1;
    end else if (s1_exp_q <= 10'sd0) begin
      result_d = {s1_sign_q, 31'd0};
      unf_d    = 1'b1;
    end else if (exp_r >= 10'sd255) begin
      result_d = {s1_sign_q, 8'hFF, 23'd0};
      ovf_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q[2] <= 1'b0;
      result_q      <= '0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
      zero_q        <= 1'b0;
    end else if (s2_adv) begin
      vld_pipe_q[2] <= vld_pipe_q[1];
      if (vld_pipe_q[1]) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
        zero_q   <= zero_d;
      end
    end
  end

  assign out_valid     = vld_pipe_q[2];
  assign out_result    = result_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;
  assign out_zero      = zero_q;

endmodule

// File: tb/tb_float_normalizer.sv
// Directed bench for float_normalizer: a vector table applied one word at a
// time, then a stall/back-pressure sequence and a reset-during-stall sequence.
module tb_float_normalizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic [4:0]  in_lead;
  logic        in_guard, in_sticky;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_overflow, out_underflow, out_zero;

  always #5 clk = ~clk;

  float_normalizer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_lead(in_lead),
    .in_guard(in_guard), .in_sticky(in_sticky),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow),
    .out_underflow(out_underflow), .out_zero(out_zero)
  );

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] mant;
    logic [4:0]  lead;
    logic        g;
    logic        s;
    logic [31:0] res;
    logic [2:0]  flags;   // {overflow, underflow, zero}
  } vec_t;

  vec_t vecs[16];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic drive(input vec_t v, input logic vld);
    in_valid  = vld;
    in_sign   = v.sign;
    in_exp    = v.exp;
    in_mant   = v.mant;
    in_lead   = v.lead;
    in_guard  = v.g;
    in_sticky = v.s;
  endtask

  // Send one word with out_ready high and wait (bounded) for its result.
  task automatic send_one(input int idx);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    drive(vecs[idx], 1'b1);
    #1;
    if (!in_ready) begin
      total++;
      $display("FAIL in_ready_v%0d: got 0 expected 1", idx);
    end
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    if (idx == 0) check("latency", 32'(lat), 32'd2);
    if (!out_valid) begin
      total++;
      $display("FAIL timeout_v%0d: out_valid never rose", idx);
    end else begin
      check($sformatf("result_v%0d", idx), out_result, vecs[idx].res);
      check($sformatf("flags_v%0d", idx),
            {29'd0, out_overflow, out_underflow, out_zero}, {29'd0, vecs[idx].flags});
    end
  endtask

  initial begin
    // sign exp mant lead g s -> result {ov,uf,z}
    vecs[0]  = '{1'b0, 8'd127, 25'h1000000, 5'd24, 1'b0, 1'b0, 32'h40000000, 3'b000};
    vecs[1]  = '{1'b0, 8'd127, 25'h0000001, 5'd0,  1'b0, 1'b0, 32'h34000000, 3'b000};
    vecs[2]  = '{1'b0, 8'd20,  25'h0000001, 5'd0,  1'b0, 1'b0, 32'h00000000, 3'b010};
    vecs[3]  = '{1'b0, 8'd127, 25'h0FFFFFF, 5'd23, 1'b1, 1'b1, 32'h40000000, 3'b000};
    vecs[4]  = '{1'b0, 8'd127, 25'h0FFFFFF, 5'd23, 1'b1, 1'b0, 32'h40000000, 3'b000};
    vecs[5]  = '{1'b1, 8'd100, 25'h0000000, 5'd23, 1'b1, 1'b1, 32'h00000000, 3'b001};
    vecs[6]  = '{1'b1, 8'd254, 25'h1000000, 5'd24, 1'b0, 1'b0, 32'hFF800000, 3'b100};
    vecs[7]  = '{1'b0, 8'd127, 25'h0C00000, 5'd23, 1'b0, 1'b0, 32'h3FC00000, 3'b000};
    vecs[8]  = '{1'b0, 8'd127, 25'h0800000, 5'd23, 1'b1, 1'b0, 32'h3F800000, 3'b000}; // tie, even
    vecs[9]  = '{1'b0, 8'd127, 25'h0800000, 5'd23, 1'b1, 1'b1, 32'h3F800001, 3'b000};
    vecs[10] = '{1'b0, 8'd127, 25'h1000003, 5'd24, 1'b0, 1'b0, 32'h40000002, 3'b000};
    vecs[11] = '{1'b0, 8'd127, 25'h0400000, 5'd22, 1'b1, 1'b0, 32'h3F000001, 3'b000}; // guard refill
    vecs[12] = '{1'b0, 8'd255, 25'h0800000, 5'd23, 1'b0, 1'b0, 32'h7F800000, 3'b100};
    vecs[13] = '{1'b1, 8'd23,  25'h0000001, 5'd0,  1'b0, 1'b0, 32'h80000000, 3'b010}; // exp 0
    vecs[14] = '{1'b0, 8'd24,  25'h0000001, 5'd0,  1'b0, 1'b0, 32'h00800000, 3'b000}; // exp 1
    vecs[15] = '{1'b0, 8'd127, 25'h1FFFFFF, 5'd24, 1'b0, 1'b0, 32'h40800000, 3'b000};

    rst_n = 1'b0; out_ready = 1'b0;
    drive(vecs[0], 1'b0);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_flags", {29'd0, out_overflow, out_underflow, out_zero}, 32'd0);
    #22 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 16; i++) send_one(i);

    // Stall: out_ready low for 4 cycles while 3 words are offered back-to-back.
    begin
      int idx = 0, n = 0, sidx[3];
      logic acc, take;
      sidx[0] = 0; sidx[1] = 7; sidx[2] = 1;
      for (int cyc = 0; cyc < 40 && n < 3; cyc++) begin
        @(negedge clk);
        if (cyc == 2 || cyc == 4) begin
          check($sformatf("stall_hold_c%0d", cyc), out_result, vecs[0].res);
          check($sformatf("stall_valid_c%0d", cyc), {31'd0, out_valid}, 32'd1);
        end
        if (cyc == 4) begin
          check("stall_accepted", 32'(idx), 32'd2);
          check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = (cyc >= 4);
        if (idx < 3) drive(vecs[sidx[idx]], 1'b1);
        else in_valid = 1'b0;
        #1;
        acc  = in_valid && in_ready;
        take = out_valid && out_ready;
        if (take) check($sformatf("stall_order_%0d", n), out_result, vecs[sidx[n]].res);
        @(posedge clk);
        if (acc) idx++;
        if (take) n++;
      end
      check("stall_drained", 32'(n), 32'd3);
      @(negedge clk);
      in_valid = 1'b0;
    end

    // Reset during a stall: two words in flight, then async reset.
    @(negedge clk);
    out_ready = 1'b0;
    drive(vecs[6], 1'b1);
    @(negedge clk);
    drive(vecs[7], 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result", out_result, 32'd0);
    check("mid_rst_flags", {29'd0, out_overflow, out_underflow, out_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    begin
      logic seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      check("post_rst_no_ghost", {31'd0, seen}, 32'd0);
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
